d_mem_sync: RTL
===============

D_MEM_SYNC -- requirements
Module: d_mem_sync

Interface
REQ-001 SHALL have parameter DEPTH, default 64, giving memory size in 32-bit words (power of two, 4..4096).
REQ-002 SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-003 SHALL have parameter WAIT_STATES, default 1, giving extra access cycles (0..15).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-008 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_unsigned  input  1  zero-extend loads (byte/half only).
REQ-011 SHALL have port req_addr  input  ADDR_W  byte address, little-endian.
REQ-012 SHALL have port req_wdata  input  32  store data; low bytes used for byte/half.
REQ-013 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-014 SHALL have port resp_rdata  output  32  load result.
REQ-015 SHALL have port resp_err  output  1  request rejected (misaligned/illegal/out of range).

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a cycle with req_valid && req_ready, latching all req_* fields; req_* ignored otherwise (no queuing).
REQ-018 On accept, SHALL go IDLE->WAIT if WAIT_STATES>0, else IDLE->RESP.
REQ-019 SHALL stay in WAIT for exactly WAIT_STATES cycles (down-counter), then go to RESP.
REQ-020 SHALL hold RESP exactly one cycle with resp_valid=1, then return to IDLE; latency accept-edge to resp_valid = WAIT_STATES+1 cycles.
REQ-021 SHALL decode word index = addr[ADDR_W-1:2], byte lane = addr[1:0].
REQ-022 SHALL flag error when: size=11; half with addr[0]=1; word with addr[1:0]!=0; word index >= DEPTH.
REQ-023 On error, SHALL not modify memory, and SHALL drive resp_err=1, resp_rdata=0 in RESP.
REQ-024 Stores SHALL commit on the clock edge entering RESP, writing only the addressed lanes (1, 2 or 4 bytes); other bytes unchanged.
REQ-025 Loads SHALL select the addressed lanes, sign-extend byte/half unless req_unsigned=1; word loads ignore req_unsigned.
REQ-026 For stores, resp_rdata SHALL be 0 in RESP.
REQ-027 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
REQ-028 A load following a store to the same address SHALL return the stored data (single outstanding access, no hazard).
REQ-029 In RESP, req_ready=0; a request asserted in RESP SHALL be accepted only from the following IDLE cycle.

Reset
REQ-030 On reset=1 at a rising edge, SHALL enter IDLE, clear wait counter; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 from the next cycle.
REQ-031 Reset during WAIT SHALL discard the pending request: no store commit, no resp_valid.
REQ-032 Memory contents SHALL not be cleared by reset.

Verification
REQ-033 WAIT_STATES=1: sw 0x8000_00F1 @0x10, then lw @0x10 -> resp_valid two cycles after each accept; rdata 0x8000_00F1, err 0.
REQ-034 After REQ-033: lb @0x10 -> 0xFFFF_FFF1; lbu @0x10 -> 0x0000_00F1; lh @0x12 -> 0xFFFF_8000; lhu @0x12 -> 0x0000_8000.
REQ-035 sb 0xAB @0x11, then lw @0x10 -> 0x8000_ABF1 (other lanes preserved).
REQ-036 lw @0x12, sh @0x13, size=11 @0x0, lw @(DEPTH*4) -> each resp_err=1, rdata=0, memory unchanged (recheck lw @0x10 = 0x8000_ABF1).
REQ-037 WAIT_STATES=3: sw 0x1234_5678 @0x20, assert reset in second WAIT cycle -> no resp_valid, req_ready=1 after reset; lw @0x20 returns prior contents, not 0x1234_5678.
REQ-038 req_valid held high continuously with WAIT_STATES=0 -> accepts every second cycle (IDLE, RESP alternating), resp_valid pulses one cycle each.

Source files
------------

// File: rtl/d_mem_sync.sv
// d_mem_sync: single-port word memory with byte/half/word loads and stores,
// a fixed number of wait states per access and a one-cycle response strobe.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; accepting one latches all req_* fields
// WAIT  | access in flight; down-counter runs for WAIT_STATES cycles
// RESP  | resp_valid high for one cycle with the latched result
module d_mem_sync #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic [31:0] mem [DEPTH];

    logic              accept;
    logic              go_resp;
    logic              eff_write;
    logic [1:0]        eff_size;
    logic              eff_uns;
    logic [ADDR_W-1:0] eff_addr;
    logic [31:0]       eff_wdata;
    logic [1:0]        eff_lane;
    logic [AW-1:0]     eff_idx;
    logic              eff_err;
    logic [3:0]        byte_en;
    logic [31:0]       wr_lanes;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       load_val;
    logic              mem_we;

    assign accept  = (state_q == S_IDLE) && req_valid;
    assign go_resp = (accept && (WAIT_STATES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd1));

    // With zero wait states the access completes on the accept edge, so the
    // live request fields are used in IDLE and the latched copy afterwards.
    always_comb begin
        eff_write = write_q;
        eff_size  = size_q;
        eff_uns   = uns_q;
        eff_addr  = addr_q;
        eff_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            eff_write = req_write;
            eff_size  = req_size;
            eff_uns   = req_unsigned;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
        end
    end

    assign eff_lane = eff_addr[1:0];
    assign eff_idx  = eff_addr[AW+1:2];

    // Error decode: illegal size, misalignment, or word index past the end.
    always_comb begin
        eff_err = 1'b0;
        if (eff_size == 2'b11)                          eff_err = 1'b1;
        if ((eff_size == 2'b01) && eff_addr[0])         eff_err = 1'b1;
        if ((eff_size == 2'b10) && (eff_lane != 2'b00)) eff_err = 1'b1;
        if ({2'b00, eff_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH)) eff_err = 1'b1;
    end

    // Store lane enables and replicated write data.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = eff_wdata;
        case (eff_size)
            2'b00: begin
                byte_en  = 4'b0001 << eff_lane;
                wr_lanes = {4{eff_wdata[7:0]}};
            end
            2'b01: begin
                byte_en  = 4'b0011 << eff_lane;
                wr_lanes = {2{eff_wdata[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // Load lane select with sign or zero extension.
    always_comb begin
        rd_word  = mem[eff_idx];
        rd_shift = rd_word >> {eff_lane, 3'b000};
        case (eff_size)
            2'b00:   load_val = eff_uns ? {24'd0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = eff_uns ? {16'd0, rd_shift[15:0]}
                                        : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase
    end

    assign mem_we = go_resp && !reset && !eff_err && eff_write;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, latched request and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= req_write;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (go_resp) begin
                err_q   <= eff_err;
                rdata_q <= (eff_err || eff_write) ? 32'd0 : load_val;
            end
        end
    end

    // Storage array; deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[eff_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;

endmodule
